// File: rtl/div_unit.sv
// Sequential restoring divider: one trial subtraction per clock, DIV/DIVU semantics.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;        // partial remainder (magnitude)
    logic [WIDTH-1:0]   quo_q, quo_d;        // dividend magnitude shifting out, quotient bits in
    logic [WIDTH-1:0]   dsr_q, dsr_d;        // divisor magnitude
    logic [WIDTH-1:0]   dvd_q, dvd_d;        // raw dividend, returned as remainder on divide by zero
    logic               qneg_q, qneg_d;      // negate quotient in FIX
    logic               rneg_q, rneg_d;      // negate remainder in FIX
    logic               dz_q, dz_d;          // current operation is a divide by zero
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               div_by_zero_q, div_by_zero_d;

    logic               dvd_neg;
    logic               dsr_neg;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dsr_q         <= '0;
            dvd_q         <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dsr_q         <= dsr_d;
            dvd_q         <= dvd_d;
            qneg_q        <= qneg_d;
            rneg_q        <= rneg_d;
            dz_q          <= dz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    // Next-state logic: operand capture, one restoring step per CALC cycle, sign fix-up
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dsr_d         = dsr_q;
        dvd_d         = dvd_q;
        qneg_d        = qneg_q;
        rneg_d        = rneg_q;
        dz_d          = dz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        dvd_neg = is_signed & dividend[WIDTH-1];
        dsr_neg = is_signed & divisor[WIDTH-1];
        // rem_sh < 2*dsr always, so WIDTH+1 bits hold both the shift and the trial sign
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, dsr_q};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d  = dividend;
                    quo_d  = dvd_neg ? -dividend : dividend;
                    dsr_d  = dsr_neg ? -divisor : divisor;
                    rem_d  = '0;
                    qneg_d = dvd_neg ^ dsr_neg;
                    rneg_d = dvd_neg;
                    cnt_d  = CNT_W'(WIDTH - 1);
                    busy_d = 1'b1;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                end else begin
                    quotient_d  = qneg_q ? -quo_q : quo_q;
                    remainder_d = rneg_q ? -rem_q : rem_q;
                end
                div_by_zero_d = dz_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results per issued division.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_res;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic, truncating division with remainder taking the dividend's sign
    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
            return e;
        end
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        e.q  = W'(sa / sb);
        e.r  = W'(sa % sb);
        e.dz = 1'b0;
        return e;
    endfunction

    // Drive start for one cycle from a negedge; returns at the negedge after the start edge
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start     = 1'b0;
        is_signed = 1'($urandom);
        dividend  = W'($urandom);
        divisor   = W'($urandom);
    endtask

    // Wait for done, reporting latency in cycles (-1 on timeout) and any busy/done overlap
    task automatic wait_done(input int budget, output int lat, output logic clash);
        lat   = -1;
        clash = 1'b0;
        for (int n = 0; n <= budget; n++) begin
            if (busy && done) clash = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dz=%b required all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_unsigned();
        logic [W-1:0] a [2];
        logic [W-1:0] b [2];
        exp_t         e [2];
        exp_t         got;
        int           lat;
        logic         clash;
        a = '{32'd100, 32'hFFFF_FFFF};
        b = '{32'd7, 32'd1};
        e = '{'{32'd14, 32'd2, 1'b0}, '{32'hFFFF_FFFF, 32'd0, 1'b0}};
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back(e[i]);
            issue(1'b0, a[i], b[i]);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL unsigned_busy_rise[%0d]: busy=%b required 1", i, busy);
            end
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== last_res) begin
                n_fail++;
                $display("FAIL unsigned_outputs_held[%0d]: q=%h r=%h required q=%h r=%h",
                         i, quotient, remainder, last_res.q, last_res.r);
            end
            wait_done(100, lat, clash);
            n_checks++;
            if (lat != 33) begin
                n_fail++;
                $display("FAIL unsigned_latency[%0d]: got %0d cycles required 33", i, lat);
            end
            n_checks++;
            if (clash) begin
                n_fail++;
                $display("FAIL unsigned_busy_done_overlap[%0d]: overlap seen, required none", i);
            end
            got = sb_q.pop_front();
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== got) begin
                n_fail++;
                $display("FAIL unsigned_result[%0d]: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                         i, quotient, remainder, div_by_zero, got.q, got.r, got.dz);
            end
            last_res = got;
            @(negedge clk);
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL unsigned_done_pulse[%0d]: done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] a [3];
        logic [W-1:0] b [3];
        exp_t         e [3];
        exp_t         got;
        int           lat;
        logic         clash;
        a = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
        b = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        e = '{'{32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0},
              '{32'h8000_0000, 32'd0, 1'b0},
              '{32'hFFFF_FFFE, 32'd1, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(e[i]);
            issue(1'b1, a[i], b[i]);
            wait_done(100, lat, clash);
            n_checks++;
            if (lat != 33) begin
                n_fail++;
                $display("FAIL signed_latency[%0d]: got %0d cycles required 33", i, lat);
            end
            got = sb_q.pop_front();
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== got) begin
                n_fail++;
                $display("FAIL signed_result[%0d]: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                         i, quotient, remainder, div_by_zero, got.q, got.r, got.dz);
            end
            last_res = got;
            @(negedge clk);
        end
    endtask

    task automatic test_div_by_zero();
        exp_t got;
        int   lat;
        logic clash;
        sb_q.push_back('{32'hFFFF_FFFF, 32'h0000_1234, 1'b1});
        issue(1'b0, 32'h0000_1234, 32'd0);
        wait_done(10, lat, clash);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL div0_latency: got %0d cycles required 1", lat);
        end
        n_checks++;
        if (clash) begin
            n_fail++;
            $display("FAIL div0_busy_done_overlap: overlap seen, required none");
        end
        got = sb_q.pop_front();
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== got) begin
            n_fail++;
            $display("FAIL div0_result: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                     quotient, remainder, div_by_zero, got.q, got.r, got.dz);
        end
        last_res = got;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic         s [3];
        logic [W-1:0] a [3];
        logic [W-1:0] b [3];
        int           el [3];
        exp_t         got;
        int           lat;
        logic         clash;
        s  = '{1'b0, 1'b1, 1'b1};
        a  = '{32'd1000, 32'hFFFF_FF00, 32'hFFFF_FF9C};
        b  = '{32'd10, 32'd0, 32'd3};
        el = '{33, 1, 33};
        sb_q.push_back(model(s[0], a[0], b[0]));
        issue(s[0], a[0], b[0]);
        for (int i = 0; i < 3; i++) begin
            wait_done(100, lat, clash);
            n_checks++;
            if (lat != el[i]) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got %0d cycles required %0d", i, lat, el[i]);
            end
            got = sb_q.pop_front();
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== got) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                         i, quotient, remainder, div_by_zero, got.q, got.r, got.dz);
            end
            last_res = got;
            // Next start presented in the very cycle done is high
            if (i < 2) begin
                sb_q.push_back(model(s[i+1], a[i+1], b[i+1]));
                issue(s[i+1], a[i+1], b[i+1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        exp_t got;
        int   lat;
        logic clash;
        sb_q.push_back('{32'd14, 32'd2, 1'b0});
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        issue(1'b1, 32'd50, 32'd0);
        n_checks++;
        if ({busy, quotient, remainder, div_by_zero} !== {1'b1, last_res}) begin
            n_fail++;
            $display("FAIL ignored_start_midop: busy=%b q=%h r=%h required busy=1 q=%h r=%h",
                     busy, quotient, remainder, last_res.q, last_res.r);
        end
        wait_done(100, lat, clash);
        n_checks++;
        if (lat != 23) begin
            n_fail++;
            $display("FAIL ignored_start_latency: got %0d cycles after cycle 10 required 23", lat);
        end
        got = sb_q.pop_front();
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== got) begin
            n_fail++;
            $display("FAIL ignored_start_result: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                     quotient, remainder, div_by_zero, got.q, got.r, got.dz);
        end
        last_res = got;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL ignored_start_no_restart: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        exp_t got;
        int   lat;
        logic clash;
        issue(1'b1, 32'hFFFF_FF9C, 32'd3);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b q=%h r=%h dz=%b required all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        last_res = '0;
        wait_done(50, lat, clash);
        n_checks++;
        if (lat != -1) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done seen after %0d cycles, required none", lat);
        end
        n_checks++;
        if ({busy, quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_held_zero: busy=%b q=%h r=%h dz=%b required all zero",
                     busy, quotient, remainder, div_by_zero);
        end
        sb_q.push_back('{32'd1, 32'd0, 1'b0});
        issue(1'b0, 32'd7, 32'd7);
        wait_done(100, lat, clash);
        got = sb_q.pop_front();
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== got || lat != 33) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got q=%h r=%h dz=%b lat=%0d required q=%h r=%h dz=%b lat=33",
                     quotient, remainder, div_by_zero, lat, got.q, got.r, got.dz);
        end
        last_res = got;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         got;
        int           lat;
        logic         clash;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = W'($urandom);
            case (i % 4)
                0:       b = W'($urandom_range(1, 255));
                1:       b = (i % 8 == 1) ? '0 : W'($urandom);
                2:       b = -W'($urandom_range(1, 1000));
                default: b = W'($urandom) >> $urandom_range(0, 31);
            endcase
            sb_q.push_back(model(s, a, b));
            issue(s, a, b);
            wait_done(100, lat, clash);
            n_checks++;
            if (lat != ((b == '0) ? 1 : 33) || clash) begin
                n_fail++;
                $display("FAIL random_timing[%0d]: lat=%0d overlap=%b for divisor %h", i, lat, clash, b);
            end
            got = sb_q.pop_front();
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== got) begin
                n_fail++;
                $display("FAIL random_result[%0d] %s %h/%h: got q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                         i, s ? "DIV" : "DIVU", a, b, quotient, remainder, div_by_zero,
                         got.q, got.r, got.dz);
            end
            last_res = got;
            @(negedge clk);
        end
    endtask

    // Test sequence
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        last_res  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
        $fatal(1);
    end

endmodule
